// File: rtl/csr_intc.sv
// -----------------------------------------------------------------------------
// csr_intc -- machine-mode CSR block with a single external interrupt source.
//
// Holds mstatus (MIE/MPIE), mtvec, mepc and, optionally, mcause. It also
// synchronizes the asynchronous interrupt line and turns each new rising edge
// into a pending flag. The control FSM sees the interrupt request on
// intrpt_vld. It reports interrupt entry with int_taken and return with
// mret_exec.
//
// Optional feature: define CSR_MCAUSE_EN to build the mcause register.
// Without it, mcause reads as zero and writes to 0x342 are ignored.
//
// Ports
//   clk        in   1  system clock, rising-edge
//   rst        in   1  synchronous active-high reset
//   intr_in    in   1  external interrupt request (asynchronous)
//   int_taken  in   1  interrupt entry this cycle
//   mret_exec  in   1  mret retiring this cycle
//   csr_we     in   1  CSR write strobe
//   csr_addr   in  12  CSR address
//   csr_wd     in  32  CSR write data
//   pc         in  32  resume PC captured into mepc on interrupt entry
//   csr_rd     out 32  combinational read data (pre-write value)
//   mtvec      out 32  trap vector register
//   mepc       out 32  exception PC register
//   intrpt_vld out  1  pending AND mstatus.MIE
// -----------------------------------------------------------------------------
module csr_intc (
    input  logic        clk,
    input  logic        rst,
    input  logic        intr_in,
    input  logic        int_taken,
    input  logic        mret_exec,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wd,
    input  logic [31:0] pc,
    output logic [31:0] csr_rd,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        intrpt_vld
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_hist;
    logic [1:0]  r_sync_vld;
    logic        r_pending;
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] w_mcause_rd;
    logic        w_rise;
    logic        w_wr_mstatus;
    logic        w_wr_mtvec;
    logic        w_wr_mepc;

    assign w_wr_mstatus = csr_we & (csr_addr == ADDR_MSTATUS);
    assign w_wr_mtvec   = csr_we & (csr_addr == ADDR_MTVEC);
    assign w_wr_mepc    = csr_we & (csr_addr == ADDR_MEPC);

    // Edge detect is only armed after reset, once r_sync2 holds a real sample
    // of intr_in rather than the reset value. r_hist starts at 1 so the first
    // real sample never counts as a rise. A level held high through reset
    // must therefore fall and rise again before it can set pending.
    assign w_rise = r_sync_vld[1] & r_sync2 & ~r_hist;

    // Two-flop synchronizer, edge-detect history and post-reset arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_vld <= 2'b00;
            r_hist     <= 1'b1;
        end else begin
            r_sync1    <= intr_in;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_hist     <= r_sync_vld[1] ? r_sync2 : 1'b1;
        end
    end

    // Pending flag: a new rising edge wins over the clear from interrupt entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_rise) begin
            r_pending <= 1'b1;
        end else if (int_taken) begin
            r_pending <= 1'b0;
        end
    end

    // mstatus MIE/MPIE: interrupt entry, then mret, then CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
        end else if (int_taken) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
        end else if (mret_exec) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mie  <= csr_wd[3];
            r_mpie <= csr_wd[7];
        end
    end

    // mepc: captured on interrupt entry, otherwise CSR-writable; always word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mepc <= 32'h0000_0000;
        end else if (int_taken) begin
            r_mepc <= pc & ALIGN_MASK;
        end else if (w_wr_mepc) begin
            r_mepc <= csr_wd & ALIGN_MASK;
        end
    end

    // mtvec: CSR-writable only; always word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtvec <= 32'h0000_0000;
        end else if (w_wr_mtvec) begin
            r_mtvec <= csr_wd & ALIGN_MASK;
        end
    end

`ifdef CSR_MCAUSE_EN
    logic [31:0] r_mcause;
    logic        w_wr_mcause;

    assign w_wr_mcause = csr_we & (csr_addr == ADDR_MCAUSE);

    // mcause: fixed external-interrupt cause on entry, otherwise full CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcause <= 32'h0000_0000;
        end else if (int_taken) begin
            r_mcause <= CAUSE_EXT;
        end else if (w_wr_mcause) begin
            r_mcause <= csr_wd;
        end
    end

    assign w_mcause_rd = r_mcause;
`else
    assign w_mcause_rd = 32'h0000_0000;
`endif

    // Read mux: registers only, so a write in this cycle still shows the old value.
    always_comb begin
        csr_rd = 32'h0000_0000;
        case (csr_addr)
            ADDR_MSTATUS: csr_rd = {24'h00_0000, r_mpie, 3'b000, r_mie, 3'b000};
            ADDR_MTVEC:   csr_rd = r_mtvec;
            ADDR_MEPC:    csr_rd = r_mepc;
            ADDR_MCAUSE:  csr_rd = w_mcause_rd;
            ADDR_MIP:     csr_rd = {20'h0_0000, r_pending, 11'h000};
            default:      csr_rd = 32'h0000_0000;
        endcase
    end

    assign mtvec      = r_mtvec;
    assign mepc       = r_mepc;
    assign intrpt_vld = r_pending & r_mie;

endmodule

// File: tb/tb_csr_intc.sv
// -----------------------------------------------------------------------------
// tb_csr_intc -- self-checking bench for csr_intc.
// Directed scenarios followed by randomized traffic. A behavioural model
// checks every cycle. The model keeps a queue of intr_in samples taken since
// the last reset. A rise counts only if both the 0 sample and the later 1
// sample were taken after reset. The 1 sample must be two edges old, which
// accounts for the synchronizer.
// -----------------------------------------------------------------------------
module tb_csr_intc;

    logic        clk = 1'b0;
    logic        rst;
    logic        intr_in;
    logic        int_taken;
    logic        mret_exec;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] pc;
    logic [31:0] csr_rd;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        intrpt_vld;

    always #5 clk = ~clk;

    csr_intc dut (
        .clk        (clk),
        .rst        (rst),
        .intr_in    (intr_in),
        .int_taken  (int_taken),
        .mret_exec  (mret_exec),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wd     (csr_wd),
        .pc         (pc),
        .csr_rd     (csr_rd),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .intrpt_vld (intrpt_vld)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_known = 1'b0;
    bit          m_mie, m_mpie, m_pend;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    bit          m_samp[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        case (a)
            12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_pend ? 32'h0000_0800 : 32'h0000_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_step();
        bit          rise;
        bit          n_mie, n_mpie;
        int          n;
        if (rst) begin
            m_known  = 1'b1;
            m_mie    = 1'b0;
            m_mpie   = 1'b0;
            m_pend   = 1'b0;
            m_mtvec  = 32'h0;
            m_mepc   = 32'h0;
            m_mcause = 32'h0;
            m_samp.delete();
        end else begin
            m_samp.push_back(intr_in);
            n    = m_samp.size();
            rise = (n >= 4) && m_samp[n-3] && !m_samp[n-4];
            if (n > 8) void'(m_samp.pop_front());

            n_mie  = m_mie;
            n_mpie = m_mpie;
            if (int_taken) begin
                n_mpie = m_mie;
                n_mie  = 1'b0;
            end else if (mret_exec) begin
                n_mie  = m_mpie;
                n_mpie = 1'b1;
            end else if (csr_we && csr_addr == 12'h300) begin
                n_mie  = csr_wd[3];
                n_mpie = csr_wd[7];
            end

            if (int_taken) m_mepc = {pc[31:2], 2'b00};
            else if (csr_we && csr_addr == 12'h341) m_mepc = {csr_wd[31:2], 2'b00};

            if (csr_we && csr_addr == 12'h305) m_mtvec = {csr_wd[31:2], 2'b00};

`ifdef CSR_MCAUSE_EN
            if (int_taken) m_mcause = 32'h8000_000B;
            else if (csr_we && csr_addr == 12'h342) m_mcause = csr_wd;
`endif
            if (rise) m_pend = 1'b1;
            else if (int_taken) m_pend = 1'b0;
            m_mie  = n_mie;
            m_mpie = n_mpie;
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, and cross one edge.
    task automatic do_cycle(input bit a_rst, input bit a_intr, input bit a_it, input bit a_mret,
                            input bit a_we, input logic [11:0] a_addr, input logic [31:0] a_wd,
                            input logic [31:0] a_pc);
        rst       = a_rst;
        intr_in   = a_intr;
        int_taken = a_it;
        mret_exec = a_mret;
        csr_we    = a_we;
        csr_addr  = a_addr;
        csr_wd    = a_wd;
        pc        = a_pc;
        #1;
        if (m_known) begin
            check_val("csr_rd", csr_rd, model_rd(a_addr));
            check_val("mtvec", mtvec, m_mtvec);
            check_val("mepc", mepc, m_mepc);
            check_val("intrpt_vld", {31'h0, intrpt_vld}, {31'h0, m_pend & m_mie});
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input logic [11:0] a, input string tag, input logic [31:0] exp);
        csr_addr  = a;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        #1;
        check_val(tag, csr_rd, exp);
    endtask

    task automatic idle(input bit a_intr);
        do_cycle(1'b0, a_intr, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
    endtask

    initial begin
        bit          r_rst, r_intr, r_it, r_mret, r_we;
        logic [11:0] r_addr;

        // reset
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h305, 32'hFFFF_FFFF, 32'h0);
        check_val("rst_mtvec", mtvec, 32'h0);
        check_val("rst_vld", {31'h0, intrpt_vld}, 32'h0);
        peek(12'h300, "rst_mstatus", 32'h0);

        // mtvec alignment
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h305, 32'h0000_0103, 32'h0);
        check_val("mtvec_align", mtvec, 32'h0000_0100);
        peek(12'h305, "rd_mtvec", 32'h0000_0100);

        // MIE=1, interrupt pulse, 3-edge latency
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h0);
        idle(1'b1);
        check_val("lat_e1", {31'h0, intrpt_vld}, 32'h0);
        idle(1'b0);
        check_val("lat_e2", {31'h0, intrpt_vld}, 32'h0);
        idle(1'b0);
        check_val("lat_e3", {31'h0, intrpt_vld}, 32'h1);

        // interrupt entry
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0044);
        check_val("entry_mepc", mepc, 32'h0000_0044);
        check_val("entry_vld", {31'h0, intrpt_vld}, 32'h0);
        peek(12'h300, "entry_mstatus", 32'h0000_0080);
`ifdef CSR_MCAUSE_EN
        peek(12'h342, "entry_mcause", 32'h8000_000B);
`else
        peek(12'h342, "entry_mcause", 32'h0);
`endif

        // mret
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0, 32'h0);
        peek(12'h300, "mret_mstatus", 32'h0000_0088);

        // pending with MIE=0, then enable
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h300, 32'h0, 32'h0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        check_val("mie0_vld", {31'h0, intrpt_vld}, 32'h0);
        peek(12'h344, "mip_pend", 32'h0000_0800);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h0);
        check_val("enable_vld", {31'h0, intrpt_vld}, 32'h1);

        // int_taken beats a same-cycle mstatus write
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h0000_0010);
        peek(12'h300, "prio_mstatus", 32'h0000_0080);

        // level held high through reset
        idle(1'b1);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        peek(12'h344, "held_no_pend", 32'h0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        peek(12'h344, "rearm_e2", 32'h0);
        idle(1'b1);
        peek(12'h344, "rearm_e3", 32'h0000_0800);

        // randomized traffic
        r_intr = 1'b0;
        for (int c = 0; c < 600; c++) begin
            r_rst  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 4) == 0) r_intr = ~r_intr;
            r_it   = ($urandom_range(0, 5) == 0);
            r_mret = ($urandom_range(0, 5) == 0);
            r_we   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 6))
                0:       r_addr = 12'h300;
                1:       r_addr = 12'h305;
                2:       r_addr = 12'h341;
                3:       r_addr = 12'h342;
                4:       r_addr = 12'h344;
                5:       r_addr = 12'h300;
                default: r_addr = 12'($urandom);
            endcase
            do_cycle(r_rst, r_intr, r_it, r_mret, r_we, r_addr, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_intc.md
CSR_INTC -- requirements
Module: csr_intc

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 intr_in  input  1  external interrupt request, asynchronous to clk.
REQ-004 int_taken  input  1  control-FSM pulse: interrupt entry this cycle.
REQ-005 mret_exec  input  1  pulse: mret retiring this cycle.
REQ-006 csr_we  input  1  CSR write strobe, from the csrrw execute cycle.
REQ-007 csr_addr  input  12  CSR address, instruction bits [31:20].
REQ-008 csr_wd  input  32  CSR write data (rs1 value).
REQ-009 pc  input  32  PC of the instruction to resume at, captured into mepc.
REQ-010 csr_rd  output  32  combinational read data for csr_addr.
REQ-011 mtvec  output  32  trap vector to the PC mux.
REQ-012 mepc  output  32  return address to the PC mux.
REQ-013 intrpt_vld  output  1  interrupt request to the control FSM.

Function
REQ-014 intr_in SHALL pass through a 2-flop synchronizer; a 0->1 transition on the synchronized signal SHALL set the pending flag on the next edge. Latency from intr_in to pending is 3 rising edges.
REQ-015 A level held high SHALL set pending once only; a new request requires a falling edge followed by a rising edge.
REQ-016 intrpt_vld SHALL be pending AND mstatus.MIE, with no registered delay.
REQ-017 On int_taken, the following SHALL all update on one edge:
- mepc <= {pc[31:2],2'b00}
- MPIE <= MIE
- MIE <= 0
- pending <= 0
- mcause <= 32'h8000000B (when enabled)
REQ-018 If a new synchronized rising edge coincides with int_taken, pending SHALL end set, because set has priority over clear.
REQ-019 On mret_exec: MIE <= MPIE and MPIE <= 1.
REQ-020 On csr_we, the addressed CSR SHALL be written:
- 0x300 mstatus: only bits 3 (MIE) and 7 (MPIE) are writable.
- 0x305 mtvec: bits [1:0] forced to 0.
- 0x341 mepc: bits [1:0] forced to 0.
- 0x342 mcause: see Configuration.
- Any other address: write ignored.
REQ-021 Same-cycle priority SHALL be int_taken > mret_exec > csr_we. A lower-priority update to a register that a higher-priority event touches SHALL be dropped. Updates to untouched registers proceed.
REQ-022 csr_rd SHALL return:
- 0x300: {24'b0, MPIE, 3'b0, MIE, 3'b0}
- 0x305 mtvec; 0x341 mepc; 0x342 mcause
- 0x344 mip: {20'b0, pending, 11'b0}
- Any other address: 0
REQ-023 csr_rd SHALL show pre-write values during the csr_we cycle, giving csrrw read-old/write-new semantics.
REQ-024 The mtvec and mepc outputs SHALL be the register contents directly.

Reset
REQ-025 On rst, the following SHALL be 0 on the next edge: mstatus, mtvec, mepc, mcause, pending and both synchronizer flops.
REQ-026 rst SHALL override all same-cycle events, including int_taken. intrpt_vld SHALL be 0 in the cycle after reset.
REQ-027 A request whose synchronized edge is in flight during rst SHALL be discarded. A level still high after reset SHALL NOT set pending until it falls and rises again.

Configuration
REQ-028 Macro CSR_MCAUSE_EN controls the mcause register.
- Defined: mcause exists, is written by int_taken, and is writable at 0x342 (full 32 bits).
- Undefined: no mcause storage; reads of 0x342 return 0 and writes to it are ignored.

Verification
REQ-029 rst, then csr_we addr 0x305 data 32'h0000_0103 -> csr_rd(0x305) = 32'h0000_0100 and mtvec = 32'h0000_0100.
REQ-030 MIE=1, pulse intr_in -> intrpt_vld=1 on the 3rd edge. Then int_taken with pc=32'h0000_0044 -> next cycle:
- mepc = 32'h0000_0044
- intrpt_vld = 0
- csr_rd(0x300) = 32'h0000_0080
- mcause = 32'h8000000B when enabled
REQ-031 With the state after REQ-030, mret_exec -> csr_rd(0x300) = 32'h0000_0088.
REQ-032 MIE=0, intr_in rising -> intrpt_vld stays 0 and csr_rd(0x344) = 32'h0000_0800. Writing mstatus 32'h8 -> intrpt_vld=1 the next cycle.
REQ-033 int_taken and csr_we addr 0x300 data 32'h8 in the same cycle -> MIE = 0 afterwards.
REQ-034 intr_in held high through rst and beyond -> pending stays 0. Drop then raise intr_in -> pending = 1 three edges after the rise.
